// File: rtl/ppm_tx_frame_sched.sv
// ppm_tx_frame_sched: transmit-side frame scheduler for the PPM transmitter.
// Arbitrates round-robin between two requesters, loads the winner's payload
// into ppm_frame_buffer (Le/N/Din), sends an SOF byte through shift_two,
// triggers payload transmission, waits for frame_done and enforces an
// inter-frame gap.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req0/1, len0/1, din0/1          requester level request, byte count, FWFT data
//   rd0/1, done0/1, err             consume strobe, completion pulse, error pulse
//   buf_le, buf_n, buf_din          buffer load interface (buf_din combinational)
//   user_recv_done                  buffer finished receiving the payload
//   start_trans, frame_done         buffer transmit trigger / completion
//   sof_data, sof_strobe, tx_sel    SOF byte, valid and shift_two source select
//   shift_two_data_send_done        shift_two byte-sent pulse
//   busy                            high in every state except idle
module ppm_tx_frame_sched #(
    parameter logic [7:0]  SOF_BYTE   = 8'hA5,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] len0,
    input  logic [3:0] len1,
    input  logic [7:0] din0,
    input  logic [7:0] din1,
    output logic       rd0,
    output logic       rd1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic       buf_le,
    output logic [3:0] buf_n,
    output logic [7:0] buf_din,
    input  logic       user_recv_done,
    output logic       start_trans,
    input  logic       frame_done,
    output logic [7:0] sof_data,
    output logic       sof_strobe,
    output logic       tx_sel,
    input  logic       shift_two_data_send_done,
    output logic       busy
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RECV, S_WAIT_RECV, S_SOF, S_START, S_WAIT_DONE, S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             finish, fail;

    logic       rd0_q, rd1_q, done0_q, done1_q, err_q, buf_le_q;
    logic       sof_strobe_q, start_trans_q, tx_sel_q, busy_q;
    logic [7:0] sof_data_q;

    // Next-state, grant and counter logic
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        len_d      = len_q;
        byte_cnt_d = '0;
        tmo_cnt_d  = '0;
        gap_cnt_d  = '0;
        finish     = 1'b0;
        fail       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester not served last wins
                    gnt_d  = (req0 && req1) ? ~last_q : req1;
                    last_d = gnt_d;
                    len_d  = gnt_d ? len1 : len0;
                    if (len_d == 4'd0) begin
                        finish  = 1'b1;
                        fail    = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: state_d = S_RECV;
            S_RECV: begin
                if (byte_cnt_q == len_q - 4'd1) begin
                    state_d = S_WAIT_RECV;
                end else begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                end
            end
            S_WAIT_RECV: if (user_recv_done) state_d = S_SOF;
            S_SOF: if (shift_two_data_send_done) state_d = S_START;
            S_START: begin
                // Timeout window starts with the start_trans cycle
                tmo_cnt_d = TMO_W'(1);
                state_d   = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (frame_done) begin
                    finish  = 1'b1;
                    state_d = S_GAP;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
                    finish  = 1'b1;
                    fail    = 1'b1;
                    state_d = S_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs (outputs decoded from next state)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            rd0_q         <= 1'b0;
            rd1_q         <= 1'b0;
            done0_q       <= 1'b0;
            done1_q       <= 1'b0;
            err_q         <= 1'b0;
            buf_le_q      <= 1'b0;
            sof_strobe_q  <= 1'b0;
            sof_data_q    <= '0;
            start_trans_q <= 1'b0;
            tx_sel_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            len_q         <= len_d;
            byte_cnt_q    <= byte_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            rd0_q         <= (state_d == S_RECV) && !gnt_d;
            rd1_q         <= (state_d == S_RECV) && gnt_d;
            done0_q       <= finish && !gnt_d;
            done1_q       <= finish && gnt_d;
            err_q         <= fail;
            buf_le_q      <= (state_d == S_LOAD);
            sof_strobe_q  <= (state_d == S_SOF);
            sof_data_q    <= (state_d == S_SOF) ? SOF_BYTE : 8'h00;
            start_trans_q <= (state_d == S_START);
            tx_sel_q      <= (state_d == S_START) || (state_d == S_WAIT_DONE);
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign rd0         = rd0_q;
    assign rd1         = rd1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign err         = err_q;
    assign buf_le      = buf_le_q;
    assign buf_n       = len_q;
    assign sof_strobe  = sof_strobe_q;
    assign sof_data    = sof_data_q;
    assign start_trans = start_trans_q;
    assign tx_sel      = tx_sel_q;
    assign busy        = busy_q;

    // Pass the granted byte straight through while reading; zero otherwise so
    // the buffer input is quiet in reset and between frames
    assign buf_din = rd0_q ? din0 : (rd1_q ? din1 : 8'h00);

endmodule

// File: tb/tb_ppm_tx_frame_sched.sv
`timescale 1ns/1ps
module tb_ppm_tx_frame_sched;

    localparam int GAP = 16;
    localparam int TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] len0 = 4'd0, len1 = 4'd0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic       user_recv_done = 1'b0, frame_done = 1'b0, shift_two_data_send_done = 1'b0;
    logic       rd0, rd1, done0, done1, err, buf_le, sof_strobe, start_trans, tx_sel, busy;
    logic [3:0] buf_n;
    logic [7:0] buf_din, sof_data;

    ppm_tx_frame_sched #(.SOF_BYTE(8'hA5), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1), .din0(din0), .din1(din1),
        .rd0(rd0), .rd1(rd1), .done0(done0), .done1(done1), .err(err),
        .buf_le(buf_le), .buf_n(buf_n), .buf_din(buf_din),
        .user_recv_done(user_recv_done), .start_trans(start_trans), .frame_done(frame_done),
        .sof_data(sof_data), .sof_strobe(sof_strobe), .tx_sel(tx_sel),
        .shift_two_data_send_done(shift_two_data_send_done), .busy(busy)
    );

    always #5 clk = ~clk;

    wire [29:0] outvec = {rd0, rd1, done0, done1, err, buf_le, sof_strobe, start_trans,
                          busy, tx_sel, buf_n, sof_data, buf_din};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Requester payload memories (first-word-fall-through model)
    logic [7:0] pay0 [16];
    logic [7:0] pay1 [16];
    int idx0 = 0, idx1 = 0;

    // Event recorder, sampled mid-cycle
    int n_le = 0, le_n = 0, le_cyc = 0, n_rd0 = 0, n_rd1 = 0, rd_first_cyc = 0;
    int n_st = 0, st_cyc = 0, n_sof = 0, n_sof_bad = 0;
    int n_done0 = 0, n_done1 = 0, done_cyc = 0, n_err = 0, n_err_alone = 0, busy_low_cyc = 0;
    logic [7:0] bytes [$];
    int gq [$];
    bit prev_rd = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (buf_le) begin n_le++; le_n = int'(buf_n); le_cyc = cyc; end
        if (rd0) begin n_rd0++; bytes.push_back(buf_din); end
        if (rd1) begin n_rd1++; bytes.push_back(buf_din); end
        if ((rd0 || rd1) && !prev_rd) rd_first_cyc = cyc;
        prev_rd = rd0 || rd1;
        if (start_trans) begin n_st++; st_cyc = cyc; end
        if (sof_strobe) begin
            n_sof++;
            if (sof_data !== 8'hA5 || tx_sel !== 1'b0) n_sof_bad++;
        end
        if (done0) begin n_done0++; done_cyc = cyc; gq.push_back(0); end
        if (done1) begin n_done1++; done_cyc = cyc; gq.push_back(1); end
        if (err) begin n_err++; if (!(done0 || done1)) n_err_alone++; end
        if (prev_busy && !busy) busy_low_cyc = cyc;
        prev_busy = busy;
    end

    // One clock; advances the FWFT pointers for bytes consumed this cycle
    task automatic tick();
        bit r0, r1;
        r0 = rd0;
        r1 = rd1;
        @(posedge clk);
        #1;
        if (r0 && idx0 < 15) idx0++;
        if (r1 && idx1 < 15) idx1++;
        din0 = pay0[idx0];
        din1 = pay1[idx1];
    endtask

    // Plays buffer and shift_two for one granted frame until a done pulse
    task automatic serve(input bit send_fd, input bit stray,
                         output int sd_c, output int fd_c, output bit to);
        bit seen_rd, urd_given, st_seen;
        int sof_n, st_n;
        seen_rd = 0; urd_given = 0; st_seen = 0; sof_n = 0; st_n = 0;
        sd_c = -1; fd_c = -1; to = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            user_recv_done = 1'b0;
            shift_two_data_send_done = 1'b0;
            frame_done = 1'b0;
            if (done0 || done1) begin to = 1'b0; break; end
            if (rd0 || rd1) begin
                seen_rd = 1;
                if (stray) begin frame_done = 1'b1; shift_two_data_send_done = 1'b1; end
            end else if (seen_rd && !urd_given) begin
                user_recv_done = 1'b1;
                urd_given = 1;
            end
            if (sof_strobe) begin
                if (sof_n == 2) begin shift_two_data_send_done = 1'b1; sd_c = cyc; end
                else if (stray) frame_done = 1'b1;
                sof_n++;
            end
            if (start_trans) st_seen = 1;
            else if (st_seen) begin
                st_n++;
                if (send_fd && st_n == 3) begin frame_done = 1'b1; fd_c = cyc; end
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!busy) begin to = 1'b0; break; end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outvec !== 30'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outvec); end
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (outvec !== 30'd0) begin errors++; $display("FAIL idle_outputs got %h want 0", outvec); end
    endtask

    task automatic test_single();
        int c, sd_c, fd_c, le0, r0, st0, d0, e0, s0, base;
        bit to;
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        le0 = n_le; r0 = n_rd0; st0 = n_st; d0 = n_done0; e0 = n_err; s0 = n_sof; base = bytes.size();
        for (int i = 0; i < 3; i++) pay0[i] = exp[i];
        idx0 = 0; din0 = pay0[0]; len0 = 4'd3; req0 = 1'b1; c = cyc;
        serve(1'b1, 1'b0, sd_c, fd_c, to);
        req0 = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL single_done got none want done0"); end
        checks++; if (n_le - le0 != 1 || le_n != 3) begin errors++; $display("FAIL single_le got %0d pulses n=%0d want 1 n=3", n_le - le0, le_n); end
        checks++; if (le_cyc != c + 1) begin errors++; $display("FAIL single_le_cyc got %0d want %0d", le_cyc, c + 1); end
        checks++; if (rd_first_cyc != c + 2) begin errors++; $display("FAIL single_rd_cyc got %0d want %0d", rd_first_cyc, c + 2); end
        checks++; if (n_rd0 - r0 != 3) begin errors++; $display("FAIL single_rd_count got %0d want 3", n_rd0 - r0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bytes.size() <= base + i || bytes[base + i] !== exp[i]) begin
                errors++; $display("FAIL single_byte%0d want %h", i, exp[i]);
            end
        end
        checks++; if (n_sof - s0 != 3 || n_sof_bad != 0) begin errors++; $display("FAIL single_sof got %0d cycles bad=%0d want 3 bad=0", n_sof - s0, n_sof_bad); end
        checks++; if (n_st - st0 != 1 || st_cyc != sd_c + 1) begin errors++; $display("FAIL single_start got %0d at %0d want 1 at %0d", n_st - st0, st_cyc, sd_c + 1); end
        checks++; if (n_done0 - d0 != 1 || done_cyc != fd_c + 1) begin errors++; $display("FAIL single_done0 got %0d at %0d want 1 at %0d", n_done0 - d0, done_cyc, fd_c + 1); end
        checks++; if (n_err != e0) begin errors++; $display("FAIL single_err got %0d want 0", n_err - e0); end
        wait_idle(to);
        checks++; if (to || busy_low_cyc - done_cyc != GAP + 1) begin errors++; $display("FAIL single_gap got %0d want %0d", busy_low_cyc - done_cyc, GAP + 1); end
    endtask

    task automatic test_zero_len();
        int c, le0, st0, d1, e0, ea, r1;
        bit to;
        le0 = n_le; st0 = n_st; d1 = n_done1; e0 = n_err; ea = n_err_alone; r1 = n_rd1;
        len1 = 4'd0; req1 = 1'b1; c = cyc;
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); if (done1) begin to = 1'b0; break; end end
        @(negedge clk); #1;
        req1 = 1'b0;
        checks++; if (to || done_cyc != c + 1) begin errors++; $display("FAIL zero_done_cyc got %0d want %0d", done_cyc, c + 1); end
        checks++; if (n_done1 - d1 != 1 || n_err - e0 != 1 || n_err_alone != ea) begin errors++; $display("FAIL zero_done_err got done=%0d err=%0d want 1 1 together", n_done1 - d1, n_err - e0); end
        checks++; if (n_le != le0 || n_st != st0 || n_rd1 != r1) begin errors++; $display("FAIL zero_no_buf got le=%0d st=%0d rd=%0d want 0", n_le - le0, n_st - st0, n_rd1 - r1); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL zero_idle got busy want idle"); end
    endtask

    task automatic test_timeout();
        int sd_c, fd_c, d0, e0, ea;
        bit to;
        d0 = n_done0; e0 = n_err; ea = n_err_alone;
        pay0[0] = 8'h01; pay0[1] = 8'h02; idx0 = 0; din0 = pay0[0];
        len0 = 4'd2; req0 = 1'b1;
        serve(1'b0, 1'b0, sd_c, fd_c, to);
        req0 = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL timeout_done got none want done0"); end
        checks++; if (n_done0 - d0 != 1 || n_err - e0 != 1 || n_err_alone != ea) begin errors++; $display("FAIL timeout_err got done=%0d err=%0d want 1 1", n_done0 - d0, n_err - e0); end
        checks++; if (done_cyc - st_cyc != TMO) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", done_cyc - st_cyc, TMO); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL timeout_idle got busy want idle"); end
    endtask

    task automatic test_full_len();
        int sd_c, fd_c, r0, d0, e0, st0, base;
        bit to;
        r0 = n_rd0; d0 = n_done0; e0 = n_err; st0 = n_st; base = bytes.size();
        for (int i = 0; i < 16; i++) pay0[i] = 8'(8'h40 + i);
        idx0 = 0; din0 = pay0[0]; len0 = 4'd15; req0 = 1'b1;
        serve(1'b1, 1'b1, sd_c, fd_c, to);
        req0 = 1'b0;
        checks++; if (to || n_rd0 - r0 != 15) begin errors++; $display("FAIL full_rd_count got %0d want 15", n_rd0 - r0); end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (bytes.size() <= base + i || bytes[base + i] !== 8'(8'h40 + i)) begin
                errors++; $display("FAIL full_byte%0d want %h", i, 8'(8'h40 + i));
            end
        end
        checks++; if (n_st - st0 != 1 || n_done0 - d0 != 1 || n_err != e0) begin errors++; $display("FAIL full_stray got st=%0d done=%0d err=%0d want 1 1 0", n_st - st0, n_done0 - d0, n_err - e0); end
        checks++; if (done_cyc != fd_c + 1) begin errors++; $display("FAIL full_done_cyc got %0d want %0d", done_cyc, fd_c + 1); end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL full_idle got busy want idle"); end
    endtask

    task automatic test_reset_mid_frame();
        int n, sd_c, fd_c, d0, e0, base;
        bit to;
        logic [7:0] exp [3];
        d0 = n_done0; e0 = n_err;
        for (int i = 0; i < 16; i++) pay0[i] = 8'(8'h80 + i);
        idx0 = 0; din0 = pay0[0]; len0 = 4'd15; req0 = 1'b1;
        n = 0; to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rd0) begin n++; if (n == 4) begin to = 1'b0; break; end end
        end
        checks++; if (to) begin errors++; $display("FAIL rst_recv got no rd0 want rd0"); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (outvec !== 30'd0) begin errors++; $display("FAIL rst_async got %h want 0", outvec); end
        req0 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        @(negedge clk); #1;
        checks++; if (n_done0 != d0 || n_err != e0 || busy !== 1'b0) begin errors++; $display("FAIL rst_no_done got done=%0d err=%0d busy=%b want 0 0 0", n_done0 - d0, n_err - e0, busy); end
        exp[0] = 8'h5A; exp[1] = 8'h6B; exp[2] = 8'h7C;
        for (int i = 0; i < 3; i++) pay0[i] = exp[i];
        idx0 = 0; din0 = pay0[0]; len0 = 4'd3; base = bytes.size();
        req0 = 1'b1;
        serve(1'b1, 1'b0, sd_c, fd_c, to);
        req0 = 1'b0;
        checks++; if (to || n_done0 - d0 != 1 || n_err != e0) begin errors++; $display("FAIL rst_clean_frame got done=%0d err=%0d want 1 0", n_done0 - d0, n_err - e0); end
        checks++;
        if (bytes.size() - base != 3 || bytes[base] !== exp[0] || bytes[base + 1] !== exp[1] || bytes[base + 2] !== exp[2]) begin
            errors++; $display("FAIL rst_clean_bytes got %0d bytes want 5a 6b 7c", bytes.size() - base);
        end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL rst_idle got busy want idle"); end
    endtask

    task automatic test_back_to_back();
        int sd_c, fd_c, gbase, prev_done;
        bit to;
        for (int i = 0; i < 16; i++) begin pay0[i] = 8'(8'hC0 + i); pay1[i] = 8'(8'hB0 + i); end
        idx0 = 0; idx1 = 0; din0 = pay0[0]; din1 = pay1[0];
        len0 = 4'd2; len1 = 4'd2;
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        rst_n = 1'b1;
        gbase = gq.size();
        prev_done = 0;
        for (int k = 0; k < 4; k++) begin
            serve(1'b1, 1'b0, sd_c, fd_c, to);
            checks++; if (to) begin errors++; $display("FAIL fair_frame%0d got none want done", k); end
            if (k > 0) begin
                checks++;
                if (le_cyc - prev_done < GAP + 1) begin errors++; $display("FAIL fair_spacing%0d got %0d want >=%0d", k, le_cyc - prev_done, GAP + 1); end
            end
            prev_done = done_cyc;
            if (done0) begin idx0 = 0; din0 = pay0[0]; end
            if (done1) begin idx1 = 0; din1 = pay1[0]; end
        end
        req0 = 1'b0; req1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gq.size() <= gbase + k || gq[gbase + k] != (k % 2)) begin
                errors++; $display("FAIL fair_order%0d want %0d", k, k % 2);
            end
        end
        wait_idle(to);
        checks++; if (to) begin errors++; $display("FAIL fair_idle got busy want idle"); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin pay0[i] = 8'h00; pay1[i] = 8'h00; end
        test_reset();
        test_single();
        test_zero_len();
        test_timeout();
        test_full_len();
        test_reset_mid_frame();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
